// File: rtl/demsk_uart_pkg.sv
// demsk_uart_pkg
// Shared definitions for the demodulated-word UART packer: the packet FSM
// state type, packet geometry and the default frame header bytes.
`timescale 1ns/1ps
package demsk_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_CSUM
  } pkt_state_t;

  // Packet = 2 header bytes + DATA_BYTES payload bytes + 1 checksum byte
  localparam int PKT_LEN    = 11;
  localparam int DATA_BYTES = 8;

  localparam logic [7:0] DEF_HDR0 = 8'hEB;
  localparam logic [7:0] DEF_HDR1 = 8'h90;

endpackage

// File: rtl/demsk_word_fifo.sv
// demsk_word_fifo
// Synchronous first-word-fall-through FIFO for demodulated words.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   wr_en, wr_data  - write request; ignored when full unless a read
//                     happens in the same cycle
//   rd_en, rd_data  - pop request; rd_data always shows the head word
//   full, empty     - occupancy flags
//   level           - number of stored words
`timescale 1ns/1ps
module demsk_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // The extra pointer MSB acts as a lap bit: equal addresses with different
  // lap bits means full, identical pointers means empty.
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO without touching storage
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Word storage, written at the current write address
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/demsk_uart_packer.sv
// demsk_uart_packer
// Buffers 64-bit demodulated words and serialises each one into an 11-byte
// frame (HDR0, HDR1, 8 data bytes MSB first, 8-bit additive checksum of the
// data bytes) for the UART transmitter over a valid/ready byte handshake.
// Ports:
//   clk_200m, cfg_rst                - clock, synchronous active-high reset
//   demsk_data, demsk_data_valid     - incoming word and its strobe
//   tx_byte, tx_byte_valid,
//   tx_byte_ready                    - byte stream to the UART TX
//   fifo_level                       - words waiting in the FIFO
//   overflow_cnt                     - dropped words, saturating
//   pkt_cnt                          - completed packets, wrapping
//   busy                             - a packet is in progress
`timescale 1ns/1ps
module demsk_uart_packer
  import demsk_uart_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] HDR0       = DEF_HDR0,
  parameter logic [7:0] HDR1       = DEF_HDR1
) (
  input  logic                          clk_200m,
  input  logic                          cfg_rst,
  input  logic [DATA_BYTES*8-1:0]       demsk_data,
  input  logic                          demsk_data_valid,
  output logic [7:0]                    tx_byte,
  output logic                          tx_byte_valid,
  input  logic                          tx_byte_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_cnt,
  output logic [15:0]                   pkt_cnt,
  output logic                          busy
);

  // Position of the last payload byte within the frame
  localparam logic [3:0] LAST_DATA_POS = 4'(PKT_LEN - 2);

  pkt_state_t                state;
  logic [DATA_BYTES*8-1:0]   shift;
  logic [7:0]                csum;
  logic [7:0]                data_sum;
  logic [3:0]                byte_pos;
  logic [DATA_BYTES*8-1:0]   fifo_rd_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;
  logic                      drop;

  // The head word is taken as soon as the FSM is idle and data is waiting
  assign pop      = (state == ST_IDLE) && !fifo_empty;
  assign drop     = demsk_data_valid && fifo_full && !pop;
  assign data_sum = csum + shift[DATA_BYTES*8-1 -: 8];
  assign busy     = (state != ST_IDLE);

  demsk_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BYTES*8)
  ) u_fifo (
    .clk     (clk_200m),
    .rst     (cfg_rst),
    .wr_en   (demsk_data_valid),
    .wr_data (demsk_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Packet FSM. tx_byte always holds the byte of the current state, so it is
  // loaded with the next byte on each accepted transfer and stays put while
  // the UART stalls. In DATA, tx_byte equals the top byte of shift.
  always_ff @(posedge clk_200m) begin
    if (cfg_rst) begin
      state         <= ST_IDLE;
      shift         <= '0;
      csum          <= '0;
      byte_pos      <= '0;
      tx_byte       <= '0;
      tx_byte_valid <= 1'b0;
      pkt_cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state         <= ST_HDR0;
            shift         <= fifo_rd_data;
            csum          <= '0;
            byte_pos      <= '0;
            tx_byte       <= HDR0;
            tx_byte_valid <= 1'b1;
          end
        end
        ST_HDR0: begin
          if (tx_byte_ready) begin
            state    <= ST_HDR1;
            tx_byte  <= HDR1;
            byte_pos <= byte_pos + 4'd1;
          end
        end
        ST_HDR1: begin
          if (tx_byte_ready) begin
            state    <= ST_DATA;
            tx_byte  <= shift[DATA_BYTES*8-1 -: 8];
            byte_pos <= byte_pos + 4'd1;
          end
        end
        ST_DATA: begin
          if (tx_byte_ready) begin
            csum     <= data_sum;
            shift    <= shift << 8;
            byte_pos <= byte_pos + 4'd1;
            // After the last payload byte the running sum is the checksum
            if (byte_pos == LAST_DATA_POS) begin
              state   <= ST_CSUM;
              tx_byte <= data_sum;
            end else begin
              tx_byte <= shift[DATA_BYTES*8-9 -: 8];
            end
          end
        end
        ST_CSUM: begin
          if (tx_byte_ready) begin
            state         <= ST_IDLE;
            tx_byte       <= '0;
            tx_byte_valid <= 1'b0;
            pkt_cnt       <= pkt_cnt + 16'd1;
          end
        end
        default: begin
          state         <= ST_IDLE;
          tx_byte_valid <= 1'b0;
        end
      endcase
    end
  end

  // Dropped-word counter; sticks at all-ones instead of wrapping
  always_ff @(posedge clk_200m) begin
    if (cfg_rst) begin
      overflow_cnt <= '0;
    end else if (drop && (overflow_cnt != 16'hFFFF)) begin
      overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_demsk_uart_packer.sv
// tb_demsk_uart_packer
// Scoreboard bench: every accepted word pushes its 11 expected frame bytes
// (built from the word with plain arithmetic) into a queue, and a monitor
// pops and compares on each valid/ready transfer. Directed sequences cover
// latency, backpressure, overflow, full-with-pop, back-to-back framing and
// reset mid-packet; a randomized phase follows.
`timescale 1ns/1ps
module tb_demsk_uart_packer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] val;
    bit         last;
  } exp_byte_t;

  logic        clk_200m = 1'b0;
  logic        cfg_rst  = 1'b1;
  logic [63:0] demsk_data = '0;
  logic        demsk_data_valid = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_byte_valid;
  logic        tx_byte_ready = 1'b0;
  logic [2:0]  fifo_level;
  logic [15:0] overflow_cnt;
  logic [15:0] pkt_cnt;
  logic        busy;

  exp_byte_t   sb_q[$];
  int          compared    = 0;
  int          mismatched  = 0;
  int          outstanding = 0;
  logic [15:0] exp_pkt     = '0;

  bit          stall_prev  = 1'b0;
  logic [7:0]  prev_byte   = '0;
  bit          pkt_pending = 1'b0;

  demsk_uart_packer #(
    .FIFO_DEPTH (DEPTH),
    .HDR0       (8'hEB),
    .HDR1       (8'h90)
  ) dut (
    .clk_200m         (clk_200m),
    .cfg_rst          (cfg_rst),
    .demsk_data       (demsk_data),
    .demsk_data_valid (demsk_data_valid),
    .tx_byte          (tx_byte),
    .tx_byte_valid    (tx_byte_valid),
    .tx_byte_ready    (tx_byte_ready),
    .fifo_level       (fifo_level),
    .overflow_cnt     (overflow_cnt),
    .pkt_cnt          (pkt_cnt),
    .busy             (busy)
  );

  always #5 clk_200m = ~clk_200m;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Inputs change 2 ns after the rising edge; outputs are sampled at the
  // falling edge.
  task automatic nextCycle();
    @(posedge clk_200m);
    #2;
  endtask

  // Reference frame: headers, payload MSB first, sum of payload mod 256
  task automatic expectPacket(input logic [63:0] word);
    int         sum;
    logic [7:0] b;
    sum = 0;
    sb_q.push_back('{val: 8'hEB, last: 1'b0});
    sb_q.push_back('{val: 8'h90, last: 1'b0});
    for (int i = 0; i < 8; i++) begin
      b   = 8'((word >> (56 - 8 * i)) & 64'hFF);
      sum = (sum + int'(b)) % 256;
      sb_q.push_back('{val: b, last: 1'b0});
    end
    sb_q.push_back('{val: 8'(sum), last: 1'b1});
  endtask

  task automatic applyStimulus(input logic [63:0] word, input bit accept);
    demsk_data       = word;
    demsk_data_valid = 1'b1;
    if (accept) begin
      expectPacket(word);
      outstanding++;
    end
    nextCycle();
    demsk_data_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || tx_byte_valid) && n < budget) begin
      nextCycle();
      n++;
    end
    checkOutput("drain_left", 64'(sb_q.size()), 64'd0);
    repeat (2) nextCycle();
  endtask

  // Monitor: transfer checking, hold checking under backpressure and the
  // packet counter after each completed frame.
  initial begin
    exp_byte_t e;
    forever begin
      @(negedge clk_200m);
      if (cfg_rst) begin
        sb_q.delete();
        exp_pkt     = '0;
        outstanding = 0;
        stall_prev  = 1'b0;
        pkt_pending = 1'b0;
      end else begin
        if (pkt_pending) begin
          checkOutput("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
          pkt_pending = 1'b0;
        end
        if (stall_prev) begin
          checkOutput("hold_valid", 64'(tx_byte_valid), 64'd1);
          checkOutput("hold_byte", 64'(tx_byte), 64'(prev_byte));
        end
        stall_prev = tx_byte_valid && !tx_byte_ready;
        prev_byte  = tx_byte;
        if (tx_byte_valid && tx_byte_ready) begin
          if (sb_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte at %0t",
                     tx_byte, $time);
          end else begin
            e = sb_q.pop_front();
            checkOutput("tx_byte", 64'(tx_byte), 64'(e.val));
            if (e.last) begin
              exp_pkt     = exp_pkt + 16'd1;
              outstanding--;
              pkt_pending = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first;
    int last;
    int nx;
    int gaps;

    // Reset values
    repeat (3) nextCycle();
    cfg_rst = 1'b0;
    @(negedge clk_200m);
    checkOutput("rst_tx_byte", 64'(tx_byte), 64'd0);
    checkOutput("rst_valid", 64'(tx_byte_valid), 64'd0);
    checkOutput("rst_level", 64'(fifo_level), 64'd0);
    checkOutput("rst_overflow", 64'(overflow_cnt), 64'd0);
    checkOutput("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    nextCycle();

    // Single word: latency, checksum and packet count
    $display("[TB] single word");
    tx_byte_ready = 1'b1;
    applyStimulus(64'h0123456789ABCDEF, 1'b1);
    @(negedge clk_200m);
    checkOutput("lat_level", 64'(fifo_level), 64'd1);
    checkOutput("lat_valid_n1", 64'(tx_byte_valid), 64'd0);
    nextCycle();
    @(negedge clk_200m);
    checkOutput("lat_valid_n2", 64'(tx_byte_valid), 64'd1);
    checkOutput("lat_hdr0", 64'(tx_byte), 64'hEB);
    repeat (10) nextCycle();
    @(negedge clk_200m);
    checkOutput("csum_byte", 64'(tx_byte), 64'hC0);
    nextCycle();
    @(negedge clk_200m);
    checkOutput("end_valid", 64'(tx_byte_valid), 64'd0);
    checkOutput("end_pkt_cnt", 64'(pkt_cnt), 64'd1);
    nextCycle();

    // Backpressure on byte index 4
    $display("[TB] backpressure");
    applyStimulus(64'h0123456789ABCDEF, 1'b1);
    repeat (5) nextCycle();
    tx_byte_ready = 1'b0;
    @(negedge clk_200m);
    checkOutput("bp_byte4", 64'(tx_byte), 64'h45);
    repeat (3) nextCycle();
    tx_byte_ready = 1'b1;
    @(negedge clk_200m);
    checkOutput("bp_still45", 64'(tx_byte), 64'h45);
    waitDrain(100);

    // Overflow: one word popped and stalled, four stored, one dropped
    $display("[TB] overflow");
    tx_byte_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus({$urandom, $urandom}, (i < 5));
    end
    @(negedge clk_200m);
    checkOutput("ovf_level", 64'(fifo_level), 64'd4);
    checkOutput("ovf_count", 64'(overflow_cnt), 64'd1);
    checkOutput("ovf_busy", 64'(busy), 64'd1);

    // Full FIFO with a strobe in the pop cycle
    $display("[TB] full plus pop");
    nextCycle();
    tx_byte_ready = 1'b1;
    repeat (11) nextCycle();
    demsk_data       = 64'hFEDCBA9876543210;
    demsk_data_valid = 1'b1;
    expectPacket(64'hFEDCBA9876543210);
    outstanding++;
    @(negedge clk_200m);
    checkOutput("fp_idle", 64'(busy), 64'd0);
    checkOutput("fp_level_before", 64'(fifo_level), 64'd4);
    nextCycle();
    demsk_data_valid = 1'b0;
    @(negedge clk_200m);
    checkOutput("fp_level_after", 64'(fifo_level), 64'd4);
    checkOutput("fp_overflow", 64'(overflow_cnt), 64'd1);
    checkOutput("fp_busy", 64'(busy), 64'd1);
    waitDrain(300);

    // Back-to-back packets
    $display("[TB] back to back");
    tx_byte_ready = 1'b0;
    applyStimulus({$urandom, $urandom}, 1'b1);
    applyStimulus({$urandom, $urandom}, 1'b1);
    repeat (2) nextCycle();
    tx_byte_ready = 1'b1;
    first = -1;
    last  = -1;
    nx    = 0;
    gaps  = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_200m);
      if (tx_byte_valid && tx_byte_ready) begin
        if (first < 0) first = i;
        last = i;
        nx++;
      end else if (first >= 0 && nx < 22 && !tx_byte_valid) begin
        gaps++;
      end
      nextCycle();
    end
    checkOutput("b2b_span", 64'(last - first + 1), 64'd23);
    checkOutput("b2b_bytes", 64'(nx), 64'd22);
    checkOutput("b2b_gaps", 64'(gaps), 64'd1);
    waitDrain(50);

    // Randomized traffic with random backpressure
    $display("[TB] random");
    for (int c = 0; c < 400; c++) begin
      tx_byte_ready = ($urandom_range(3) != 0);
      if (outstanding < DEPTH && $urandom_range(2) == 0)
        applyStimulus({$urandom, $urandom}, 1'b1);
      else
        nextCycle();
    end
    tx_byte_ready = 1'b1;
    waitDrain(300);

    // Reset during the fourth data byte
    $display("[TB] reset mid-packet");
    applyStimulus(64'h1122334455667788, 1'b1);
    repeat (6) nextCycle();
    cfg_rst       = 1'b1;
    tx_byte_ready = 1'b0;
    nextCycle();
    cfg_rst       = 1'b0;
    tx_byte_ready = 1'b1;
    @(negedge clk_200m);
    checkOutput("mr_valid", 64'(tx_byte_valid), 64'd0);
    checkOutput("mr_level", 64'(fifo_level), 64'd0);
    checkOutput("mr_pkt_cnt", 64'(pkt_cnt), 64'd0);
    checkOutput("mr_busy", 64'(busy), 64'd0);
    nextCycle();
    applyStimulus({$urandom, $urandom}, 1'b1);
    waitDrain(50);
    checkOutput("mr_pkt_after", 64'(pkt_cnt), 64'd1);

    checkOutput("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
